fetch_buffer: RTL
=================

Name: fetch_buffer

Overview:
- Circular instruction queue between the 3-wide fetch stage and dispatch.
- Absorbs fetch bandwidth while dispatch stalls, so fetch can keep streaming while dispatch drains at its own rate.
- Accepts up to WIDTH in-order FETCH_DISPATCH_PACKETs per cycle and presents the oldest WIDTH entries to dispatch.
- Dispatch reports how many it consumed; a branch flush empties the queue.

Parameters:
- WIDTH, 3: superscalar width, lanes in and out.
- DEPTH, 8: queue entries; power of two, at least 2*WIDTH.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; buffer is reset while 0.
- branch_flush_en  input  1  mispredict recovery; empties the queue.
- fetch_in  input  WIDTH x FETCH_DISPATCH_PACKET  lanes from fetch (valid, inst[31:0], PC[31:0], NPC[31:0]); lane 0 is oldest.
- dispatch_count  input  $clog2(WIDTH+1)  number of presented entries dispatch consumed this cycle (0..WIDTH).
- accept_slots  output  $clog2(WIDTH+1)  lanes fetch may present this cycle; min(free entries, WIDTH).
- dispatch_out  output  WIDTH x FETCH_DISPATCH_PACKET  oldest entries; lane 0 is the head.
- entry_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: head_ptr and tail_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register; DEPTH-entry packet array.
- Reset (reset==0, asynchronous): head=tail=count=0 and array valid bits cleared.
  - Outputs during and after reset: entry_count=0, accept_slots=WIDTH, all dispatch_out.valid=0.
- accept_slots is combinational from registered count only. It does not depend on dispatch_count, so there is no same-cycle slot reuse.
- Enqueue:
  - enq_n is the number of contiguous valid lanes starting at lane 0; lanes after the first invalid lane are ignored.
  - enq_n is clamped to accept_slots; excess lanes are silently dropped.
  - Fetch is required never to exceed accept_slots; the bench checks for drops.
  - Accepted lane i is written to array[(tail+i) mod DEPTH] at the posedge; tail advances by enq_n.
- Dequeue:
  - dispatch_out[i] = array[(head+i) mod DEPTH], with valid=1 only when i < count.
  - Lanes with i >= count drive valid=0; inst, PC and NPC on those lanes are don't-care but must be X-free.
  - deq_n = min(dispatch_count, count); head advances by deq_n.
  - dispatch_count values above the number of valid lanes are clamped, never an error.
- Count update: count_next = count + enq_n - deq_n, all in the same cycle.
  - Full (count==DEPTH): accept_slots=0, so no enqueue; dequeue still allowed.
  - Empty: deq_n=0; enqueue allowed.
- Wrap-around: writes and reads spanning index DEPTH-1 to 0 are correct in the same cycle.
- Flush (branch_flush_en=1):
  - At the posedge, head=tail=count=0.
  - That cycle's fetch_in and dispatch_count are ignored.
  - dispatch_out still shows the pre-flush contents during the flush cycle; dispatch gates on flush itself.
  - The following cycle, all dispatch_out.valid=0.
- Latency: an entry enqueued at edge N is visible on dispatch_out after edge N (one-cycle minimum residency) unless the bypass feature is compiled in.
- Reset asserted mid-stream: all entries are discarded immediately, without waiting for a clock edge.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined: when count==0 and branch_flush_en==0:
  - dispatch_out lanes are driven combinationally from the accepted fetch_in lanes (valid only for i < enq_n).
  - deq_n = min(dispatch_count, enq_n).
  - Only the enq_n-deq_n undispatched lanes are written; tail advances by enq_n-deq_n and head does not move.
- Undefined: no combinational path from fetch_in to dispatch_out; behaviour is exactly as above.

Decomposition:
- Shared package (sys_defs) holds:
  - FETCH_DISPATCH_PACKET, already shared with fetch and dispatch.
  - Default constants FB_DEPTH and SUPERSCALAR_WIDTH=3.
  - A helper typedef for the occupancy count.
- One natural sub-module, fetch_buffer_ptr: a modulo-DEPTH pointer advance (ptr, inc -> ptr_next), instantiated once each for head and tail.
- Array storage and output muxing stay in fetch_buffer.

Test Plan:
- Reset: hold reset=0 two cycles, then release -> entry_count=0, accept_slots=3, all dispatch_out.valid=0.
- Enqueue only: fetch_in 3 valid (PC 0,4,8; inst 1,2,3), dispatch_count=0, three cycles -> entry_count 3, 6, 8; accept_slots 3, 2, 0.
  - The third cycle drops one lane; bench flags it.
  - dispatch_out shows PC 0,4,8.
- Partial dispatch: queue holds PC 0..28, dispatch_count=2 with no enqueue -> next cycle head lanes show PC 8,12,16; entry_count=6.
- Wrap-around: cycle enq/deq of 3/3 for five cycles at steady state -> PCs on dispatch_out strictly increase by 4 per entry across index 7->0; entry_count is constant.
- Flush: queue holds 5 entries; assert branch_flush_en with fetch_in valid (PC 20,24,28) -> next cycle entry_count=0, all valid=0; PC 20 is not enqueued.
- Bypass (FETCH_BUFFER_BYPASS_EN): empty queue, fetch_in PC 40,44,48, dispatch_count=1 -> same cycle dispatch_out shows PC 40,44,48 valid; next cycle entry_count=2 and head PC=44.

Source files
------------

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared fetch/dispatch packet type and default queue constants
package sys_defs;

  localparam int SUPERSCALAR_WIDTH = 3;
  localparam int FB_DEPTH          = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } FETCH_DISPATCH_PACKET;

  // Occupancy needs one bit more than a pointer so a full queue is distinct from empty.
  typedef logic [$clog2(FB_DEPTH):0] fb_count_t;

endpackage

// File: rtl/fetch_buffer_ptr.sv
// rtl/fetch_buffer_ptr.sv - modulo-DEPTH pointer advance for the fetch buffer head/tail
module fetch_buffer_ptr #(
  parameter int DEPTH = 8,
  parameter int INC_W = 2
) (
  input  logic [$clog2(DEPTH)-1:0] ptr_i,
  input  logic [INC_W-1:0]         inc_i,
  output logic [$clog2(DEPTH)-1:0] ptr_next_o
);

  localparam int PW = $clog2(DEPTH);

  // DEPTH is a power of two, so discarding the carry out is the modulo wrap.
  assign ptr_next_o = ptr_i + PW'(inc_i);

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular fetch-to-dispatch queue; FETCH_BUFFER_BYPASS_EN adds empty-queue bypass
module fetch_buffer
  import sys_defs::*;
#(
  parameter int WIDTH = SUPERSCALAR_WIDTH,
  parameter int DEPTH = FB_DEPTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              branch_flush_en,
  input  FETCH_DISPATCH_PACKET [WIDTH-1:0]  fetch_in,
  input  logic [$clog2(WIDTH+1)-1:0]        dispatch_count,
  output logic [$clog2(WIDTH+1)-1:0]        accept_slots,
  output FETCH_DISPATCH_PACKET [WIDTH-1:0]  dispatch_out,
  output logic [$clog2(DEPTH):0]            entry_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [NW-1:0] cnt_t;
  typedef logic [CW-1:0] lane_t;

  FETCH_DISPATCH_PACKET mem_q [DEPTH];
  FETCH_DISPATCH_PACKET mem_d [DEPTH];

  ptr_t  head_q, head_d, head_next;
  ptr_t  tail_q, tail_d, tail_next;
  cnt_t  count_q, count_d, free_slots;
  lane_t enq_raw, enq_n, avail_n, deq_n, head_inc, wr_n, wr_skip;
  logic  run;

  assign entry_count = count_q;

  // Fetch grant comes from registered occupancy only, capped at the lane count.
  always_comb begin
    free_slots = cnt_t'(DEPTH) - count_q;
    if (free_slots >= cnt_t'(WIDTH)) accept_slots = lane_t'(WIDTH);
    else                             accept_slots = lane_t'(free_slots);
  end

  // Work out how many lanes are written, consumed and how far each pointer moves.
  always_comb begin
    enq_raw = '0;
    run     = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run && fetch_in[i].valid) enq_raw = enq_raw + lane_t'(1);
      else                          run     = 1'b0;
    end
    enq_n    = (enq_raw > accept_slots) ? accept_slots : enq_raw;
    avail_n  = (count_q >= cnt_t'(WIDTH)) ? lane_t'(WIDTH) : lane_t'(count_q);
    deq_n    = (dispatch_count > avail_n) ? avail_n : dispatch_count;
    wr_n     = enq_n;
    wr_skip  = '0;
    head_inc = deq_n;
`ifdef FETCH_BUFFER_BYPASS_EN
    // Empty queue: dispatch takes lanes straight from fetch, only leftovers are stored.
    if ((count_q == '0) && !branch_flush_en) begin
      deq_n    = (dispatch_count > enq_n) ? enq_n : dispatch_count;
      wr_n     = enq_n - deq_n;
      wr_skip  = deq_n;
      head_inc = '0;
    end
`endif
    if (branch_flush_en) begin
      wr_n     = '0;
      head_inc = '0;
    end
  end

  fetch_buffer_ptr #(.DEPTH(DEPTH), .INC_W(CW)) u_head_ptr (
    .ptr_i      (head_q),
    .inc_i      (head_inc),
    .ptr_next_o (head_next)
  );

  fetch_buffer_ptr #(.DEPTH(DEPTH), .INC_W(CW)) u_tail_ptr (
    .ptr_i      (tail_q),
    .inc_i      (wr_n),
    .ptr_next_o (tail_next)
  );

  // Next pointers and occupancy; a flush collapses everything to empty.
  always_comb begin
    head_d  = head_next;
    tail_d  = tail_next;
    count_d = count_q + cnt_t'(wr_n) - cnt_t'(head_inc);
    if (branch_flush_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Place accepted lanes at consecutive slots from tail, skipping any bypassed lanes.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (lane_t'(i) < wr_n) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (lane_t'(j) == lane_t'(i) + wr_skip) begin
            mem_d[tail_q + ptr_t'(i)]       = fetch_in[j];
            mem_d[tail_q + ptr_t'(i)].valid = 1'b1;
          end
        end
      end
    end
  end

  // Present the oldest entries; lanes beyond occupancy are marked invalid.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      dispatch_out[i]       = mem_q[head_q + ptr_t'(i)];
      dispatch_out[i].valid = cnt_t'(i) < count_q;
    end
`ifdef FETCH_BUFFER_BYPASS_EN
    if ((count_q == '0) && !branch_flush_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        dispatch_out[i]       = fetch_in[i];
        dispatch_out[i].valid = lane_t'(i) < enq_n;
      end
    end
`endif
  end

  // State registers; reset clears the whole array so idle lanes never carry X.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule
